// File: rtl/mio_mem_responder.sv
// Responder end of the CPU memory/IO handshake: word RAM plus a small LED/switch IO
// region, with a configurable number of wait states before each single-cycle ack.
module mio_mem_responder #(
  parameter int          RAM_AW      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] IO_BASE     = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        MIO_ready,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_isWrite;
  logic        r_ready;
  logic [31:0] r_dout;
  logic [15:0] r_led;
  logic [31:0] r_mem [0:(1 << RAM_AW) - 1];

  logic        w_req;
  logic [31:0] w_accAddr;
  logic        w_accWrite;
  logic        w_accIo;
  logic [31:0] w_rdData;
  logic        w_commit;
  logic        w_commitIo;
  logic        w_unused;

  assign w_req = MemRead | MemWrite;

  // With zero wait states the request goes straight to RESP, so the read path must
  // look at the live inputs while still in IDLE rather than the latched copies.
  assign w_accAddr  = (r_state == S_IDLE) ? addr : r_addr;
  assign w_accWrite = (r_state == S_IDLE) ? MemWrite : r_isWrite;
  assign w_accIo    = (w_accAddr[31:28] == IO_BASE[31:28]);
  assign w_commit   = (r_state == S_RESP) && r_isWrite;
  assign w_commitIo = (r_addr[31:28] == IO_BASE[31:28]);
  assign w_unused   = ^{w_accAddr, r_addr};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == LP_LAST) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdData = 32'h0;
    if (w_accIo) begin
      case (w_accAddr[3:2])
        2'd0:    w_rdData = {16'h0, r_led};
        2'd1:    w_rdData = {16'h0, sw};
        default: w_rdData = 32'h0;
      endcase
    end else begin
      w_rdData = r_mem[w_accAddr[RAM_AW+1:2]];
    end
  end

  // Read data and the ack are loaded on the edge entering RESP so both are stable
  // for the whole completion cycle; writes commit on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_dout  <= 32'h0;
      r_led   <= 16'h0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_RESP);
      if (r_state == S_IDLE && w_req) begin
        r_addr    <= addr;
        r_wdata   <= data_in;
        r_isWrite <= MemWrite;
        r_cnt     <= 4'd0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_next == S_RESP && !w_accWrite) r_dout <= w_rdData;
      if (w_commit && w_commitIo && r_addr[3:2] == 2'd0) r_led <= r_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_commit && !w_commitIo) r_mem[r_addr[RAM_AW+1:2]] <= r_wdata;
  end

  assign data_out  = r_dout;
  assign MIO_ready = r_ready;
  assign led       = r_led;

endmodule

// File: tb/tb_mio_mem_responder.sv
// Directed bench for mio_mem_responder: one instance with two wait states and one
// with none, driven by hand-written transactions with hand-computed results.
module tb_mio_mem_responder;

  logic        clk;
  logic        reset;
  logic        memReadA, memWriteA, readyA;
  logic [31:0] addrA, dataInA, dataOutA;
  logic [15:0] swA, ledA;
  logic        memRead0, memWrite0, ready0;
  logic [31:0] addr0, dataIn0, dataOut0;
  logic [15:0] sw0, led0;

  int checks = 0;
  int errors = 0;

  mio_mem_responder #(.RAM_AW(10), .WAIT_CYCLES(2), .IO_BASE(32'hF000_0000)) dutA (
    .clk(clk), .reset(reset), .MemRead(memReadA), .MemWrite(memWriteA), .addr(addrA),
    .data_in(dataInA), .data_out(dataOutA), .MIO_ready(readyA), .sw(swA), .led(ledA)
  );

  mio_mem_responder #(.RAM_AW(10), .WAIT_CYCLES(0), .IO_BASE(32'hF000_0000)) dut0 (
    .clk(clk), .reset(reset), .MemRead(memRead0), .MemWrite(memWrite0), .addr(addr0),
    .data_in(dataIn0), .data_out(dataOut0), .MIO_ready(ready0), .sw(sw0), .led(led0)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Issue one request on the chosen instance, wait (bounded) for its ack, return the
  // ack latency in cycles after the request cycle and the data seen with the ack,
  // then drop the request and confirm the ack was a single-cycle pulse.
  task automatic applyStimulus(input bit sel, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d,
                               output int lat, output logic [31:0] q);
    @(negedge clk);
    if (sel) begin
      memRead0 = rd; memWrite0 = wr; addr0 = a; dataIn0 = d;
    end else begin
      memReadA = rd; memWriteA = wr; addrA = a; dataInA = d;
    end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if ((sel ? ready0 : readyA) === 1'b1) begin
        lat = k;
        break;
      end
    end
    q = sel ? dataOut0 : dataOutA;
    if (sel) begin
      memRead0 = 1'b0; memWrite0 = 1'b0;
    end else begin
      memReadA = 1'b0; memWriteA = 1'b0;
    end
    @(posedge clk); #1;
    checkOutput("pulse_width", {31'h0, sel ? ready0 : readyA}, 32'h0);
  endtask

  initial begin
    int          lat;
    logic [31:0] q;

    reset = 1'b1;
    memReadA = 1'b0; memWriteA = 1'b0; addrA = 32'h0; dataInA = 32'h0; swA = 16'h0;
    memRead0 = 1'b0; memWrite0 = 1'b0; addr0 = 32'h0; dataIn0 = 32'h0; sw0 = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_readyA", {31'h0, readyA}, 32'h0);
    checkOutput("rst_doutA", dataOutA, 32'h0);
    checkOutput("rst_ledA", {16'h0, ledA}, 32'h0);
    checkOutput("rst_ready0", {31'h0, ready0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] basic RAM write/read, two wait states");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, q);
    checkOutput("t1_wr_latency", 32'(lat), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, q);
    checkOutput("t1_rd_latency", 32'(lat), 32'd3);
    checkOutput("t1_rd_data", q, 32'hDEAD_BEEF);

    $display("[TB] address aliasing");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678, lat, q);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_1004, 32'h0, lat, q);
    checkOutput("t2_alias_data", q, 32'h1234_5678);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, q);
    checkOutput("t2_other_word", q, 32'hDEAD_BEEF);

    $display("[TB] IO region");
    swA = 16'h3C0F;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_A5A5, lat, q);
    checkOutput("t3_led", {16'h0, ledA}, 32'h0000_A5A5);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hF000_0000, 32'h0, lat, q);
    checkOutput("t3_led_rd", q, 32'h0000_A5A5);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hF000_0008, 32'h0, lat, q);
    checkOutput("t3_reserved_rd", q, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hF000_0004, 32'h0, lat, q);
    checkOutput("t3_sw_rd", q, 32'h0000_3C0F);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hF000_0004, 32'h0000_1111, lat, q);
    checkOutput("t3_sw_wr_latency", 32'(lat), 32'd3);
    checkOutput("t3_led_kept", {16'h0, ledA}, 32'h0000_A5A5);
    checkOutput("t3_dout_kept", dataOutA, 32'h0000_3C0F);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0, lat, q);
    @(negedge clk);
    memWriteA = 1'b1; addrA = 32'h0000_0020; dataInA = 32'hCAFE_0000;
    @(posedge clk); #1;
    checkOutput("t4_wait_ready", {31'h0, readyA}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    memWriteA = 1'b0;
    @(posedge clk); #1;
    checkOutput("t4_rst_ready", {31'h0, readyA}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("t4_no_ack", {31'h0, readyA}, 32'h0);
    end
    checkOutput("t4_led", {16'h0, ledA}, 32'h0);
    checkOutput("t4_dout", dataOutA, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, q);
    checkOutput("t4_rd_latency", 32'(lat), 32'd3);
    checkOutput("t4_rd_data", q, 32'h0);

    $display("[TB] zero wait states");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h5555_AAAA, lat, q);
    checkOutput("t5_wr_latency", 32'(lat), 32'd1);
    @(negedge clk);
    memRead0 = 1'b1; addr0 = 32'h0000_0000;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      checkOutput("t5_held_ready", {31'h0, ready0}, (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k == 1) checkOutput("t5_held_data", dataOut0, 32'h5555_AAAA);
      if (k == 5) memRead0 = 1'b0;
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'hABCD_0123, lat, q);
    checkOutput("t5_both_latency", 32'(lat), 32'd1);
    checkOutput("t5_both_dout", q, 32'h5555_AAAA);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, lat, q);
    checkOutput("t5_both_rd", q, 32'hABCD_0123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
